// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths for the ID/EX pipeline register: field sizes of the decoded
// instruction that crosses from decode into execute.
package id_ex_stage_reg_pkg;
  localparam int EXECUTE_COMMAND_LEN = 4;
  localparam int REG_ADDR_LEN        = 4;
  localparam int STATUS_LEN          = 4;
  localparam int SHIFT_OP_LEN        = 12;
  localparam int SIMM24_LEN          = 24;
  localparam int CTRL_BITS           = 6;  // valid, mem_read, mem_write, wb_en, branch, s
endpackage

// File: rtl/pipe_field_reg.sv
// One group of pipeline-register fields with hold (stall) and clear (bubble).
// Hold beats clear so a stalled bubble stays exactly as it was.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q_q <= '0;
    else if (hold)   q_q <= q_q;
    else if (clear)  q_q <= '0;
    else             q_q <= d;
  end

  assign q = q_q;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: one-cycle registered copy of the decoded instruction,
// with freeze (stall), flush (bubble) and saturating stall/flush counters.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = REG_ADDR_LEN,
  parameter int EXE_CMD_W = EXECUTE_COMMAND_LEN,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [DATA_W-1:0]       id_pc,
  input  logic [EXE_CMD_W-1:0]    id_exe_cmd,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    id_wb_en,
  input  logic                    id_branch,
  input  logic                    id_s,
  input  logic                    id_imm,
  input  logic [DATA_W-1:0]       id_val_rn,
  input  logic [DATA_W-1:0]       id_val_rm,
  input  logic [SHIFT_OP_LEN-1:0] id_shift_op,
  input  logic [SIMM24_LEN-1:0]   id_simm24,
  input  logic [REG_AW-1:0]       id_dest,
  input  logic [REG_AW-1:0]       id_src1,
  input  logic [REG_AW-1:0]       id_src2,
  input  logic [STATUS_LEN-1:0]   id_status,
  output logic                    ex_valid,
  output logic [DATA_W-1:0]       ex_pc,
  output logic [EXE_CMD_W-1:0]    ex_exe_cmd,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_wb_en,
  output logic                    ex_branch,
  output logic                    ex_s,
  output logic                    ex_imm,
  output logic [DATA_W-1:0]       ex_val_rn,
  output logic [DATA_W-1:0]       ex_val_rm,
  output logic [SHIFT_OP_LEN-1:0] ex_shift_op,
  output logic [SIMM24_LEN-1:0]   ex_simm24,
  output logic [REG_AW-1:0]       ex_dest,
  output logic [REG_AW-1:0]       ex_src1,
  output logic [REG_AW-1:0]       ex_src2,
  output logic [STATUS_LEN-1:0]   ex_status,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);
  localparam int CTRL_W = CTRL_BITS + EXE_CMD_W;
  localparam int DP_W   = 3 * DATA_W + 1 + SHIFT_OP_LEN + SIMM24_LEN + 3 * REG_AW + STATUS_LEN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Flush outranks freeze, so a stall never protects a squashed instruction.
  logic hold;
  assign hold = freeze & ~flush;

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DP_W-1:0]   dp_d, dp_q;

  assign ctrl_d = {id_valid, id_exe_cmd, id_mem_read, id_mem_write, id_wb_en, id_branch, id_s};
  assign dp_d   = {id_pc, id_imm, id_val_rn, id_val_rm, id_shift_op, id_simm24,
                   id_dest, id_src1, id_src2, id_status};

  // Control clears on an invalid ID slot too, which is what makes a bubble side-effect free.
  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clear(flush | ~id_valid), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_field_reg #(.W(DP_W)) u_dp (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clear(flush), .d(dp_d), .q(dp_q)
  );

  assign {ex_valid, ex_exe_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s} = ctrl_q;
  assign {ex_pc, ex_imm, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24,
          ex_dest, ex_src1, ex_src2, ex_status} = dp_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (freeze) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios then random traffic, checked by
// a scoreboard fed from a behavioural model of the stage.
module tb_id_ex_stage_reg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mr, mw, wb, br, s, imm;
    logic [31:0] rn, rm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest, src1, src2, status;
  } stage_t;

  localparam int SW = $bits(stage_t);
  localparam int EW = 2 * SW + 40;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  stage_t id = '0;

  // clock/reset block
  always #5 clk = ~clk;

  // Outputs of the wide-counter DUT (a) and the 4-bit-counter DUT (b).
  logic a_valid, a_mr, a_mw, a_wb, a_br, a_s, a_imm;
  logic [31:0] a_pc, a_rn, a_rm;
  logic [3:0] a_cmd, a_dest, a_src1, a_src2, a_status;
  logic [11:0] a_sh;
  logic [23:0] a_simm;
  logic [15:0] a_stall, a_flush;
  logic b_valid, b_mr, b_mw, b_wb, b_br, b_s, b_imm;
  logic [31:0] b_pc, b_rn, b_rm;
  logic [3:0] b_cmd, b_dest, b_src1, b_src2, b_status;
  logic [11:0] b_sh;
  logic [23:0] b_simm;
  logic [3:0] b_stall, b_flush;

  id_ex_stage_reg #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id.valid), .id_pc(id.pc), .id_exe_cmd(id.cmd), .id_mem_read(id.mr),
    .id_mem_write(id.mw), .id_wb_en(id.wb), .id_branch(id.br), .id_s(id.s), .id_imm(id.imm),
    .id_val_rn(id.rn), .id_val_rm(id.rm), .id_shift_op(id.sh), .id_simm24(id.simm),
    .id_dest(id.dest), .id_src1(id.src1), .id_src2(id.src2), .id_status(id.status),
    .ex_valid(a_valid), .ex_pc(a_pc), .ex_exe_cmd(a_cmd), .ex_mem_read(a_mr),
    .ex_mem_write(a_mw), .ex_wb_en(a_wb), .ex_branch(a_br), .ex_s(a_s), .ex_imm(a_imm),
    .ex_val_rn(a_rn), .ex_val_rm(a_rm), .ex_shift_op(a_sh), .ex_simm24(a_simm),
    .ex_dest(a_dest), .ex_src1(a_src1), .ex_src2(a_src2), .ex_status(a_status),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id.valid), .id_pc(id.pc), .id_exe_cmd(id.cmd), .id_mem_read(id.mr),
    .id_mem_write(id.mw), .id_wb_en(id.wb), .id_branch(id.br), .id_s(id.s), .id_imm(id.imm),
    .id_val_rn(id.rn), .id_val_rm(id.rm), .id_shift_op(id.sh), .id_simm24(id.simm),
    .id_dest(id.dest), .id_src1(id.src1), .id_src2(id.src2), .id_status(id.status),
    .ex_valid(b_valid), .ex_pc(b_pc), .ex_exe_cmd(b_cmd), .ex_mem_read(b_mr),
    .ex_mem_write(b_mw), .ex_wb_en(b_wb), .ex_branch(b_br), .ex_s(b_s), .ex_imm(b_imm),
    .ex_val_rn(b_rn), .ex_val_rm(b_rm), .ex_shift_op(b_sh), .ex_simm24(b_simm),
    .ex_dest(b_dest), .ex_src1(b_src1), .ex_src2(b_src2), .ex_status(b_status),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  logic [EW-1:0] act;
  assign act = {a_valid, a_pc, a_cmd, a_mr, a_mw, a_wb, a_br, a_s, a_imm, a_rn, a_rm, a_sh,
                a_simm, a_dest, a_src1, a_src2, a_status,
                b_valid, b_pc, b_cmd, b_mr, b_mw, b_wb, b_br, b_s, b_imm, b_rn, b_rm, b_sh,
                b_simm, b_dest, b_src1, b_src2, b_status,
                a_stall, a_flush, 4'(b_stall), 4'(b_flush)};

  // Reference model: what EX should hold and how many stall/flush edges occurred.
  stage_t      m_ex;
  int unsigned m_stalls, m_flushes;

  function automatic int unsigned sat(input int unsigned c, input int unsigned max);
    return (c < max) ? c + 1 : c;
  endfunction

  function automatic logic [EW-1:0] expected();
    int unsigned s16 = (m_stalls < 65535) ? m_stalls : 65535;
    int unsigned f16 = (m_flushes < 65535) ? m_flushes : 65535;
    int unsigned s4  = (m_stalls < 15) ? m_stalls : 15;
    int unsigned f4  = (m_flushes < 15) ? m_flushes : 15;
    return {m_ex, m_ex, 16'(s16), 16'(f16), 4'(s4), 4'(f4)};
  endfunction

  task automatic model_edge();
    if (flush) begin
      m_ex = '0;
      m_flushes = sat(m_flushes, 100000);
    end else if (freeze) begin
      m_stalls = sat(m_stalls, 100000);
    end else begin
      m_ex = id;
      if (!id.valid) begin
        m_ex.cmd = '0;
        {m_ex.mr, m_ex.mw, m_ex.wb, m_ex.br, m_ex.s} = '0;
      end
    end
  endtask

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int edge_no = 0;

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      edge_no++;
      checks++;
      if (act === e) passes++;
      else $display("FAIL edge_%0d: got %h expected %h", edge_no, act, e);
    end
  end

  // driver tasks: called just after an edge, set inputs, let one edge happen.
  task automatic drive(input stage_t v, input bit fz, input bit fl);
    id = v;
    freeze = fz;
    flush = fl;
    @(posedge clk);
    model_edge();
    exp_q.push_back(expected());
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    id = '1;
    rst_n = 1'b0;
    exp_q.delete();
    m_ex = '0;
    m_stalls = 0;
    m_flushes = 0;
    #1;
    checks++;
    if (act === '0) passes++;
    else $display("FAIL reset: got %h expected 0", act);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic stage_t rand_stage();
    logic [159:0] r;
    stage_t v;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    v = r[SW-1:0];
    v.valid = ($urandom_range(0, 3) != 0);
    return v;
  endfunction

  initial begin
    stage_t v;
    id = '1;
    do_reset();

    // pass-through
    v = rand_stage();
    v.valid = 1'b1; v.cmd = 4'b0010; v.wb = 1'b1; v.rn = 32'h1234_5678;
    drive(v, 1'b0, 1'b0);

    // freeze holds pc=0x10 for three stalled edges
    do_reset();
    v = rand_stage();
    v.valid = 1'b1; v.pc = 32'h10;
    drive(v, 1'b0, 1'b0);
    v.pc = 32'h14;
    for (int i = 0; i < 3; i++) drive(v, 1'b1, 1'b0);

    // flush wins over freeze
    v.mw = 1'b1;
    drive(v, 1'b1, 1'b1);

    // bubble: invalid slot with live control bits
    v = rand_stage();
    v.valid = 1'b0; v.mr = 1'b1; v.wb = 1'b1; v.mw = 1'b1; v.br = 1'b1; v.s = 1'b1;
    drive(v, 1'b0, 1'b0);
    // a stalled bubble stays a bubble
    v.valid = 1'b1;
    drive(v, 1'b1, 1'b0);

    // 4-bit stall counter saturates
    for (int i = 0; i < 20; i++) drive(rand_stage(), 1'b1, 1'b0);
    // and the flush counter too
    for (int i = 0; i < 18; i++) drive(rand_stage(), 1'b0, 1'b1);

    // reset mid-stall, then normal traffic resumes
    v = rand_stage();
    v.valid = 1'b1;
    drive(v, 1'b0, 1'b0);
    drive(rand_stage(), 1'b1, 1'b0);
    do_reset();
    drive(v, 1'b1, 1'b0);
    drive(v, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++)
      drive(rand_stage(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

    id = '0; freeze = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
